// File: rtl/hazard_detection_pkg.sv
// Shared widths, FSM encoding and the load-use compare for the hazard unit.
`include "header.vh"

package hazard_detection_pkg;

    localparam int AW = `AWIDTH;
    localparam int CW = `HZ_CWIDTH;

    typedef enum logic [1:0] {
        ST_RUN    = `HZ_RUN,
        ST_LSTALL = `HZ_LSTALL,
        ST_MWAIT  = `HZ_MWAIT
    } hz_state_t;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    function automatic logic load_use_hit(
        input logic          memread,
        input logic [AW-1:0] rd,
        input logic          use_rs1,
        input logic [AW-1:0] rs1,
        input logic          use_rs2,
        input logic [AW-1:0] rs2
    );
        return memread && (rd != '0) &&
               ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/header.vh
`ifndef HEADER_VH
`define HEADER_VH

`define AWIDTH     5
`define HZ_CWIDTH  16
`define HZ_RUN     2'd0
`define HZ_LSTALL  2'd1
`define HZ_MWAIT   2'd2

`endif

// File: rtl/hz_sat_counter.sv
// Saturating event counter: sticks at all-ones, clear and reset take precedence.
// Latency: count visible the cycle after inc. No backpressure.
// Sync active-high reset.
module hz_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_detection.sv
// Pipeline hazard unit: load-use stall, branch flush, memory-wait freeze, stat counters.
// Latency: control outputs are combinational from state and inputs; counters update next edge.
// Backpressure: mem_busy freezes the whole pipeline and outranks every other event.
module hazard_detection
    import hazard_detection_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] fs_ds_i_addr_rs1,
    input  logic [AW-1:0] fs_ds_i_addr_rs2,
    input  logic          ds_i_use_rs1,
    input  logic          ds_i_use_rs2,
    input  logic          ds_es_i_memread,
    input  logic [AW-1:0] ds_es_i_addr_rd,
    input  logic          es_i_branch_taken,
    input  logic          ms_i_mem_busy,
    input  logic          hz_i_cnt_clr,
    output logic          hz_o_pc_we,
    output logic          hz_o_fs_ds_we,
    output logic          hz_o_ds_es_bubble,
    output logic          hz_o_fs_ds_flush,
    output logic          hz_o_ds_es_flush,
    output logic          hz_o_freeze,
    output logic [1:0]    hz_o_state,
    output logic [CW-1:0] hz_o_cnt_load,
    output logic [CW-1:0] hz_o_cnt_flush,
    output logic [CW-1:0] hz_o_cnt_wait
);

    hz_state_t state_q, state_d;
    logic      lu_hit;
    logic      lu_en;

    assign lu_hit = load_use_hit(ds_es_i_memread, ds_es_i_addr_rd,
                                 ds_i_use_rs1, fs_ds_i_addr_rs1,
                                 ds_i_use_rs2, fs_ds_i_addr_rs2);

    // LSTALL has already inserted its bubble; MWAIT resumes as if in RUN
    assign lu_en = (state_q == ST_RUN) || (state_q == ST_MWAIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        hz_o_pc_we        = 1'b1;
        hz_o_fs_ds_we     = 1'b1;
        hz_o_ds_es_bubble = 1'b0;
        hz_o_fs_ds_flush  = 1'b0;
        hz_o_ds_es_flush  = 1'b0;
        hz_o_freeze       = 1'b0;
        state_d           = ST_RUN;

        if (i_rst) begin
            hz_o_pc_we    = 1'b0;
            hz_o_fs_ds_we = 1'b0;
        end else if (ms_i_mem_busy) begin
            hz_o_pc_we    = 1'b0;
            hz_o_fs_ds_we = 1'b0;
            hz_o_freeze   = 1'b1;
            state_d       = ST_MWAIT;
        end else if (es_i_branch_taken) begin
            hz_o_fs_ds_flush = 1'b1;
            hz_o_ds_es_flush = 1'b1;
        end else if (lu_en && lu_hit) begin
            hz_o_pc_we        = 1'b0;
            hz_o_fs_ds_we     = 1'b0;
            hz_o_ds_es_bubble = 1'b1;
            state_d           = ST_LSTALL;
        end

        if (!(state_q inside {ST_RUN, ST_LSTALL, ST_MWAIT})) begin
            state_d = ST_RUN;
        end
    end

    assign hz_o_state = state_q;

    hz_sat_counter #(.W(CW)) u_cnt_load (
        .clk (i_clk),
        .rst (i_rst),
        .clr (hz_i_cnt_clr),
        .inc (hz_o_ds_es_bubble),
        .cnt (hz_o_cnt_load)
    );

    hz_sat_counter #(.W(CW)) u_cnt_flush (
        .clk (i_clk),
        .rst (i_rst),
        .clr (hz_i_cnt_clr),
        .inc (hz_o_fs_ds_flush),
        .cnt (hz_o_cnt_flush)
    );

    hz_sat_counter #(.W(CW)) u_cnt_wait (
        .clk (i_clk),
        .rst (i_rst),
        .clr (hz_i_cnt_clr),
        .inc (hz_o_freeze),
        .cnt (hz_o_cnt_wait)
    );

endmodule

// File: doc/hazard_detection.md
HAZARD_DETECTION -- requirements
Module: hazard_detection

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port fs_ds_i_addr_rs1, input, `AWIDTH bits: rs1 address of the instruction in decode.
REQ-004 SHALL have port fs_ds_i_addr_rs2, input, `AWIDTH bits: rs2 address of the instruction in decode.
REQ-005 SHALL have ports ds_i_use_rs1 and ds_i_use_rs2, input, 1 bit each: the decode instruction reads rs1 or rs2.
REQ-006 SHALL have port ds_es_i_memread, input, 1 bit: the instruction in execute is a load.
REQ-007 SHALL have port ds_es_i_addr_rd, input, `AWIDTH bits: destination of the instruction in execute.
REQ-008 SHALL have port es_i_branch_taken, input, 1 bit: branch or jump resolved taken in execute.
REQ-009 SHALL have port ms_i_mem_busy, input, 1 bit: data memory not ready.
REQ-010 SHALL have port hz_i_cnt_clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-011 SHALL have outputs hz_o_pc_we, hz_o_fs_ds_we, hz_o_ds_es_bubble, hz_o_fs_ds_flush, hz_o_ds_es_flush and hz_o_freeze, 1 bit each.
REQ-012 SHALL have output hz_o_state, 2 bits: current FSM state.
REQ-013 SHALL have outputs hz_o_cnt_load, hz_o_cnt_flush and hz_o_cnt_wait, `HZ_CWIDTH bits each: statistics counters.

Function
REQ-014 SHALL implement FSM states RUN=0, LSTALL=1 and MWAIT=2; encoding 3 is unused and SHALL return to RUN on the next edge.
REQ-015 Control outputs SHALL be combinational (Mealy) from state and current inputs; zero-latency effect on the pipeline in the same cycle.
REQ-016 Load-use hit = ds_es_i_memread && rd!=0 && ((use_rs1 && rs1==rd) || (use_rs2 && rs2==rd)).
REQ-017 Priority per cycle SHALL be: mem_busy > branch_taken > load-use > none.
REQ-018 Mem_busy in any state SHALL drive freeze=1, pc_we=0, fs_ds_we=0, bubble=0 and flushes=0; next state MWAIT.
REQ-019 Branch_taken without busy SHALL drive pc_we=1, fs_ds_we=1, fs_ds_flush=1 and ds_es_flush=1, suppress any load-use hit, and set next state RUN.
REQ-020 Load-use hit in RUN (no busy, no branch) SHALL drive pc_we=0, fs_ds_we=0 and bubble=1; next state LSTALL.
REQ-021 LSTALL SHALL disable load-use detection for that cycle and return to RUN; busy and branch rules still apply.
REQ-022 MWAIT SHALL hold while busy; the first non-busy cycle SHALL evaluate as RUN (branch or load-use acted on in that cycle), with the next state chosen accordingly.
REQ-023 The default (no event) outputs SHALL be pc_we=1, fs_ds_we=1 and all others 0.
REQ-024 hz_o_cnt_load SHALL increment once per load-use bubble cycle.
REQ-025 hz_o_cnt_flush SHALL increment once per cycle in which flushes are asserted.
REQ-026 hz_o_cnt_wait SHALL increment once per freeze cycle.
REQ-027 All counters SHALL saturate at all-ones with no wrap.
REQ-028 hz_i_cnt_clr SHALL zero the counters and win over a simultaneous increment.

Reset
REQ-029 While i_rst=1, state SHALL go to RUN and the counters to 0 on the edge.
REQ-030 While i_rst=1, outputs SHALL be forced to pc_we=0, fs_ds_we=0 and all flushes, bubble and freeze 0.
REQ-031 Reset mid-MWAIT or mid-LSTALL SHALL abandon the state with no residual stall after release.

Structure
REQ-032 `HZ_RUN, `HZ_LSTALL, `HZ_MWAIT and `HZ_CWIDTH(=16) SHALL live in header.vh alongside `AWIDTH.
REQ-033 The counters SHALL use one sub-module, hz_sat_counter (inc, clr, rst, saturating), instantiated three times.

Verification
REQ-034 EX load rd=5, decode rs1=5 with use_rs1=1 -> one cycle of pc_we=0, fs_ds_we=0, bubble=1; state LSTALL; cnt_load=1; RUN next cycle.
REQ-035 EX load rd=0, decode rs1=0 -> no stall; outputs at default.
REQ-036 Load-use hit and branch_taken in the same cycle -> both flushes=1, pc_we=1, bubble=0; cnt_flush=1, cnt_load=0.
REQ-037 mem_busy high 3 cycles with a load-use hit pending -> freeze=1 for 3 cycles, cnt_wait=3; first cycle after busy drops asserts bubble=1.
REQ-038 Force cnt_wait to 16'hFFFF with a further freeze cycle -> remains 16'hFFFF; then cnt_clr=1 with an increment -> 0.
REQ-039 i_rst=1 during MWAIT -> next cycle state=RUN, counters 0, outputs at default after release.
